// File: rtl/uart_pkg.sv
// Shared UART types and defaults used by the transmit arbiter and its watchdog.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_WDT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two byte FIFOs, the UART sender and the transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int DATA_W = uart_pkg::UART_DATA_W
);
    logic              empty0;
    logic              empty1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              rd_en0;
    logic              rd_en1;
    logic              txBusy;
    logic              txDone;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic [1:0]        grant;
    logic              arb_busy;
    logic              wdt_err;
    logic              err_clr;

    // Arbiter side
    modport master (
        input  empty0, empty1, data0, data1, txBusy, txDone, err_clr,
        output rd_en0, rd_en1, tx_data, tx_start, grant, arb_busy, wdt_err
    );

    // FIFOs / sender / host side
    modport slave (
        output empty0, empty1, data0, data1, txBusy, txDone, err_clr,
        input  rd_en0, rd_en1, tx_data, tx_start, grant, arb_busy, wdt_err
    );
endinterface

// File: rtl/uart_arb_wdt.sv
// Saturating watchdog counter: cleared on load, counts while enabled, flags the last allowed cycle.
module uart_arb_wdt
    import uart_pkg::*;
#(
    parameter int WDT_CYCLES = UART_WDT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int            CW    = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WDT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender between the button FIFO (req 0) and the echo FIFO (req 1).
// Define UART_TX_ARBITER_FIXED_PRIO_EN to make requester 0 win every contention.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int WDT_CYCLES = UART_WDT_CYCLES
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_arbiter_if.master bus
);
    arb_state_t        r_state;
    logic              r_rd_en0;
    logic              r_rd_en1;
    logic              r_tx_start;
    logic [DATA_W-1:0] r_tx_data;
    logic [1:0]        r_grant;
    logic              r_arb_busy;
    logic              r_wdt_err;
    logic              r_last;

    logic [1:0]        w_req;
    logic              w_win;
    logic [DATA_W-1:0] w_data_g;
    logic              w_wdt_expire;

    assign w_req = {~bus.empty1, ~bus.empty0};

`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
    assign w_win = ~w_req[0];
`else
    assign w_win = (w_req == 2'b11) ? ~r_last : w_req[1];
`endif

    assign w_data_g = r_grant[1] ? bus.data1 : bus.data0;

    uart_arb_wdt #(
        .WDT_CYCLES (WDT_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (r_state == LOAD),
        .i_en     (r_state == WAIT_BUSY),
        .o_expire (w_wdt_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rd_en0   <= 1'b0;
            r_rd_en1   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_grant    <= '0;
            r_arb_busy <= 1'b0;
            r_wdt_err  <= 1'b0;
            r_last     <= 1'b1;
        end else begin
            r_rd_en0   <= 1'b0;
            r_rd_en1   <= 1'b0;
            r_tx_start <= 1'b0;
            // A watchdog set later in this block overrides the clear.
            if (bus.err_clr) begin
                r_wdt_err <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_req != 2'b00) begin
                        r_grant    <= {w_win, ~w_win};
                        r_rd_en0   <= ~w_win;
                        r_rd_en1   <= w_win;
                        r_arb_busy <= 1'b1;
                        r_state    <= POP;
                    end
                end
                POP: begin
                    r_tx_start <= 1'b1;
                    r_state    <= LOAD;
                end
                LOAD: begin
                    r_tx_data <= w_data_g;
                    r_state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.txBusy) begin
                        r_state <= WAIT_DONE;
                    end else if (w_wdt_expire) begin
                        r_wdt_err  <= 1'b1;
                        r_last     <= r_grant[1];
                        r_grant    <= '0;
                        r_arb_busy <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.txDone) begin
                        r_last     <= r_grant[1];
                        r_grant    <= '0;
                        r_arb_busy <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // FIFO data only arrives during LOAD, so the sender sees it straight through then.
    assign bus.tx_data  = (r_state == LOAD) ? w_data_g : r_tx_data;
    assign bus.rd_en0   = r_rd_en0;
    assign bus.rd_en1   = r_rd_en1;
    assign bus.tx_start = r_tx_start;
    assign bus.grant    = r_grant;
    assign bus.arb_busy = r_arb_busy;
    assign bus.wdt_err  = r_wdt_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: FIFO models feed bytes, tasks emulate the sender.
module tb_uart_tx_arbiter;

    localparam int TB_WDT = 16;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] g;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    int wp0 = 0;
    int wp1 = 0;
    int rp0 = 0;
    int rp1 = 0;

    uart_tx_arbiter_if #(.DATA_W(8)) bus ();

    uart_tx_arbiter #(
        .DATA_W     (8),
        .WDT_CYCLES (TB_WDT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.empty0 = (rp0 == wp0);
    assign bus.empty1 = (rp1 == wp1);

    // FIFO read data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en0) begin
            bus.data0 <= mem0[rp0 % 16];
            rp0       <= rp0 + 1;
        end
        if (bus.rd_en1) begin
            bus.data1 <= mem1[rp1 % 16];
            rp1       <= rp1 + 1;
        end
    end

    task automatic push0(input logic [7:0] d);
        mem0[wp0 % 16] = d;
        wp0++;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wp1 % 16] = d;
        wp1++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic await_start(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat = i + 1;
            if (bus.tx_start) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic finish_frame();
        bus.txBusy = 1'b1;
        repeat (4) @(negedge clk);
        bus.txBusy = 1'b0;
        bus.txDone = 1'b1;
        @(negedge clk);
        bus.txDone = 1'b0;
    endtask

    task automatic test_reset();
        bus.txBusy  = 1'b0;
        bus.txDone  = 1'b0;
        bus.err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.rd_en0, bus.rd_en1, bus.tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 000", {bus.rd_en0, bus.rd_en1, bus.tx_start});
        end
        checks++;
        if (bus.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data got %h want 00", bus.tx_data);
        end
        checks++;
        if ({bus.grant, bus.arb_busy, bus.wdt_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status got %b want 0000", {bus.grant, bus.arb_busy, bus.wdt_err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req arb_busy got %b want 0", bus.arb_busy);
        end
    endtask

    task automatic test_single();
        exp_t e;
        push0(8'h5A);
        exp_q.push_back('{d: 8'h5A, g: 2'b01});
        @(negedge clk);
        checks++;
        if ({bus.rd_en0, bus.rd_en1, bus.tx_start, bus.grant} !== 5'b10001) begin
            errors++;
            $display("FAIL single_pop got %b want 10001", {bus.rd_en0, bus.rd_en1, bus.tx_start, bus.grant});
        end
        @(negedge clk);
        checks++;
        if ({bus.rd_en0, bus.rd_en1, bus.tx_start} !== 3'b001) begin
            errors++;
            $display("FAIL single_start got %b want 001", {bus.rd_en0, bus.rd_en1, bus.tx_start});
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.tx_data, bus.grant} !== e) begin
            errors++;
            $display("FAIL single_data got %h/%b want %h/%b", bus.tx_data, bus.grant, e.d, e.g);
        end
        finish_frame();
        checks++;
        if ({bus.grant, bus.arb_busy} !== 3'b000) begin
            errors++;
            $display("FAIL single_release got %b want 000", {bus.grant, bus.arb_busy});
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int lat;
        exp_t e;
        apply_reset();
        push0(8'h11);
        push0(8'h22);
        push1(8'hA1);
        push1(8'hA2);
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
        exp_q.push_back('{d: 8'h11, g: 2'b01});
        exp_q.push_back('{d: 8'h22, g: 2'b01});
        exp_q.push_back('{d: 8'hA1, g: 2'b10});
        exp_q.push_back('{d: 8'hA2, g: 2'b10});
`else
        exp_q.push_back('{d: 8'h11, g: 2'b01});
        exp_q.push_back('{d: 8'hA1, g: 2'b10});
        exp_q.push_back('{d: 8'h22, g: 2'b01});
        exp_q.push_back('{d: 8'hA2, g: 2'b10});
`endif
        for (int i = 0; i < 4; i++) begin
            await_start(ok, lat);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_timeout byte %0d got no tx_start want tx_start", i);
            end else begin
                e = exp_q.pop_front();
                if ({bus.tx_data, bus.grant} !== e) begin
                    errors++;
                    $display("FAIL rr_order byte %0d got %h/%b want %h/%b", i, bus.tx_data, bus.grant, e.d, e.g);
                end
            end
            // txDone cycle -> IDLE -> POP -> LOAD
            if (i > 0) begin
                checks++;
                if (lat != 2) begin
                    errors++;
                    $display("FAIL rr_gap byte %0d got %0d want 2", i, lat);
                end
            end
            finish_frame();
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int lat;
        int n;
        exp_t e;
        push0(8'h3C);
        push1(8'h4D);
        exp_q.push_back('{d: 8'h3C, g: 2'b01});
        exp_q.push_back('{d: 8'h4D, g: 2'b10});
        await_start(ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wdt_first_timeout got no tx_start want tx_start");
        end else begin
            e = exp_q.pop_front();
            if ({bus.tx_data, bus.grant} !== e) begin
                errors++;
                $display("FAIL wdt_first got %h/%b want %h/%b", bus.tx_data, bus.grant, e.d, e.g);
            end
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wdt_err) break;
            if (bus.arb_busy) n++;
        end
        checks++;
        if (bus.wdt_err !== 1'b1 || n != TB_WDT) begin
            errors++;
            $display("FAIL wdt_expire got err=%b busy_cycles=%0d want err=1 busy_cycles=%0d", bus.wdt_err, n, TB_WDT);
        end
        checks++;
        if ({bus.grant, bus.arb_busy} !== 3'b000) begin
            errors++;
            $display("FAIL wdt_release got %b want 000", {bus.grant, bus.arb_busy});
        end
        await_start(ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wdt_next_timeout got no tx_start want tx_start");
        end else begin
            e = exp_q.pop_front();
            if ({bus.tx_data, bus.grant, bus.wdt_err} !== {e, 1'b1}) begin
                errors++;
                $display("FAIL wdt_next got %h/%b err=%b want %h/%b err=1", bus.tx_data, bus.grant, bus.wdt_err, e.d, e.g);
            end
        end
        finish_frame();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++;
        if (bus.wdt_err !== 1'b0) begin
            errors++;
            $display("FAIL wdt_clear got %b want 0", bus.wdt_err);
        end
    endtask

    task automatic test_collision();
        bit ok;
        int lat;
        exp_t e;
        push0(8'h77);
        exp_q.push_back('{d: 8'h77, g: 2'b01});
        await_start(ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL coll_timeout got no tx_start want tx_start");
        end else begin
            e = exp_q.pop_front();
            if ({bus.tx_data, bus.grant} !== e) begin
                errors++;
                $display("FAIL coll_data got %h/%b want %h/%b", bus.tx_data, bus.grant, e.d, e.g);
            end
        end
        // 16th WAIT_BUSY cycle is the expiry cycle
        repeat (TB_WDT) @(negedge clk);
        checks++;
        if (bus.wdt_err !== 1'b0) begin
            errors++;
            $display("FAIL coll_early got %b want 0", bus.wdt_err);
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++;
        if ({bus.wdt_err, bus.arb_busy} !== 2'b10) begin
            errors++;
            $display("FAIL coll_set_wins got %b want 10", {bus.wdt_err, bus.arb_busy});
        end
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset_wait_done();
        bit ok;
        int lat;
        exp_t e;
        push0(8'h33);
        exp_q.push_back('{d: 8'h33, g: 2'b01});
        await_start(ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstwd_timeout got no tx_start want tx_start");
        end else begin
            e = exp_q.pop_front();
            if ({bus.tx_data, bus.grant} !== e) begin
                errors++;
                $display("FAIL rstwd_data got %h/%b want %h/%b", bus.tx_data, bus.grant, e.d, e.g);
            end
        end
        bus.txBusy = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.tx_data, bus.arb_busy} !== {8'h33, 1'b1}) begin
            errors++;
            $display("FAIL rstwd_hold got %h/%b want 33/1", bus.tx_data, bus.arb_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx_data, bus.grant, bus.arb_busy} !== 11'h000) begin
            errors++;
            $display("FAIL rstwd_async got %h/%b/%b want 00/00/0", bus.tx_data, bus.grant, bus.arb_busy);
        end
        push1(8'h5B);
        exp_q.push_back('{d: 8'h5B, g: 2'b10});
        @(negedge clk);
        bus.txBusy = 1'b0;
        rst_n = 1'b1;
        await_start(ok, lat);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstwd_after_timeout got no tx_start want tx_start");
        end else begin
            e = exp_q.pop_front();
            if ({bus.tx_data, bus.grant} !== e || lat != 2) begin
                errors++;
                $display("FAIL rstwd_after got %h/%b lat=%0d want %h/%b lat=2", bus.tx_data, bus.grant, lat, e.d, e.g);
            end
        end
        finish_frame();
    endtask

    task automatic test_spurious();
        int bad;
        bad = 0;
        bus.txDone = 1'b1;
        @(negedge clk);
        bus.txDone = 1'b0;
        bus.txBusy = 1'b1;
        @(negedge clk);
        bus.txBusy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rd_en0 || bus.rd_en1 || bus.tx_start || bus.arb_busy) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spurious got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_collision();
        test_reset_wait_done();
        test_spurious();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
